noise_playback_ctrl: RTL



---
 rtl/noise_playback_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/noise_playback_ctrl.sv
// noise_playback_ctrl: steps the noise ROM address across a programmable window
// at a programmable sample rate. Playback is one-shot or looping. Each ROM word is
// registered and handed downstream over a valid/ready handshake.
// Optional build macro NOISE_GAIN_EN adds i_gain_shift. That input is latched on
// start and arithmetically attenuates every captured sample.
module noise_playback_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24,
    parameter int DIV_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_length,
    input  logic [DIV_W-1:0]  i_rate_div,
    output logic [ADDR_W-1:0] o_lut_addr,
    input  logic [DATA_W-1:0] i_lut_data,
`ifdef NOISE_GAIN_EN
    input  logic [3:0]        i_gain_shift,
`endif
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic              r_loop;
    logic [DIV_W-1:0]  r_rate;
    logic [ADDR_W-1:0] r_offset;
    logic [DIV_W-1:0]  r_div;
    logic              r_tick_pend;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_done;
    logic              r_overrun;

    logic              w_tick;
    logic              w_slot_free;
    logic              w_handshake;
    logic              w_capture;
    logic              w_last;
    logic              w_busy;
    logic              w_done_set;
    logic [ADDR_W-1:0] w_len_m1;
    logic [DATA_W-1:0] w_sample;

`ifdef NOISE_GAIN_EN
    logic [3:0]               r_gain;
    logic signed [DATA_W-1:0] w_shifted;

    // The arithmetic shift keeps the sign. A shift of DATA_W or more leaves only sign bits.
    assign w_shifted = $signed(i_lut_data) >>> r_gain;
    assign w_sample  = w_shifted;

    // The gain is latched with the rest of the configuration at start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gain <= '0;
        end else if (i_start) begin
            r_gain <= i_gain_shift;
        end
    end
`else
    assign w_sample = i_lut_data;
`endif

    // Length 0 wraps to all-ones here, so a zero length selects the full ROM depth.
    assign w_len_m1    = r_len - ADDR_ONE;
    assign w_last      = (r_offset == w_len_m1);
    assign w_tick      = (r_state == S_RUN) && (r_div == '0);
    assign w_slot_free = !r_valid || i_ready;
    assign w_handshake = r_valid && i_ready;
    // Start and stop both take priority over a capture in the same cycle.
    assign w_capture   = (r_state == S_RUN) && !i_start && !i_stop &&
                         (r_tick_pend || w_tick) && w_slot_free;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Start restarts from any state and beats a simultaneous stop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_start)                           w_state_next = S_RUN;
                else if (i_stop)                       w_state_next = S_DRAIN;
                else if (w_capture && w_last && !r_loop) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_start)                     w_state_next = S_RUN;
                else if (!r_valid || i_ready)    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: the busy flag, and the condition that sets the done pulse.
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_done_set = (r_state == S_DRAIN) && (w_state_next == S_IDLE);
    end

    // Configuration, divider, tick bookkeeping and offset sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base      <= '0;
            r_len       <= '0;
            r_loop      <= 1'b0;
            r_rate      <= '0;
            r_offset    <= '0;
            r_div       <= '0;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (i_start) begin
                r_base      <= i_base_addr;
                r_len       <= i_length;
                r_loop      <= i_loop;
                r_rate      <= i_rate_div;
                r_offset    <= '0;
                r_div       <= '0;
                r_tick_pend <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_div <= (r_div == '0) ? r_rate : (r_div - DIV_ONE);
                end
                // A second tick arriving while one is pending is lost.
                if (w_tick && r_tick_pend) begin
                    r_overrun <= 1'b1;
                end
                if (w_capture) begin
                    r_tick_pend <= 1'b0;
                end else if (w_tick) begin
                    r_tick_pend <= 1'b1;
                end
                if (w_capture) begin
                    r_offset <= w_last ? '0 : (r_offset + ADDR_ONE);
                end
            end
        end
    end

    // Output sample register. A held sample survives a restart until it is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_data  <= w_sample;
            r_valid <= 1'b1;
        end else if (w_handshake) begin
            r_valid <= 1'b0;
        end
    end

    assign o_lut_addr = r_base + r_offset;
    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_busy     = w_busy;
    assign o_done     = r_done;
    assign o_overrun  = r_overrun;

endmodule
